// File: rtl/fetch_control_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package common;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage : common

// File: rtl/fetch_control_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {W{1'b1}})) begin
            r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign count = r_count;

endmodule : sat_counter

// File: rtl/fetch_control_unit.sv
// PC and IF/ID register with stall buffering, redirect draining of stale fetches,
// and saturating stall/flush counters.
module fetch_control_unit
    import common::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite_n,
    input  logic             if_id_Write_n,
    input  logic             is_data_stall,
    input  logic             is_control_hazard,
    input  logic [31:0]      branch_target,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic             if_id_valid,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    fetch_state_t r_state, w_state_next;
    logic [31:0]  r_pc, w_pc_next;
    logic [31:0]  r_req_addr, w_req_addr_next;
    logic [31:0]  r_hold_instr, w_hold_instr_next;
    logic [31:0]  r_hold_pc, w_hold_pc_next;
    logic [31:0]  r_if_id_instr, w_if_id_instr_next;
    logic [31:0]  r_if_id_pc, w_if_id_pc_next;
    logic         r_if_id_valid, w_if_id_valid_next;
    logic         w_stall;

    assign w_stall = PCWrite_n | if_id_Write_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_req_addr    <= RESET_PC;
            r_hold_instr  <= NOP_INSTR;
            r_hold_pc     <= '0;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_pc    <= '0;
            r_if_id_valid <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_req_addr    <= w_req_addr_next;
            r_hold_instr  <= w_hold_instr_next;
            r_hold_pc     <= w_hold_pc_next;
            r_if_id_instr <= w_if_id_instr_next;
            r_if_id_pc    <= w_if_id_pc_next;
            r_if_id_valid <= w_if_id_valid_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_req_addr_next    = r_req_addr;
        w_hold_instr_next  = r_hold_instr;
        w_hold_pc_next     = r_hold_pc;
        w_if_id_instr_next = r_if_id_instr;
        w_if_id_pc_next    = r_if_id_pc;
        w_if_id_valid_next = r_if_id_valid;
        case (r_state)
            FETCH: begin
                if (imem_ready) begin
                    if (is_control_hazard) begin
                        w_pc_next          = branch_target;
                        w_if_id_valid_next = 1'b0;
                    end else if (w_stall) begin
                        w_hold_instr_next = imem_rdata;
                        w_hold_pc_next    = r_pc;
                        w_state_next      = HOLD;
                    end else begin
                        w_if_id_instr_next = imem_rdata;
                        w_if_id_pc_next    = r_pc;
                        w_if_id_valid_next = 1'b1;
                        w_pc_next          = r_pc + 32'd4;
                    end
                end else if (is_control_hazard) begin
                    // Request at r_pc is still in flight; keep presenting it until it completes.
                    w_req_addr_next    = r_pc;
                    w_pc_next          = branch_target;
                    w_if_id_valid_next = 1'b0;
                    w_state_next       = DRAIN;
                end
            end
            HOLD: begin
                if (is_control_hazard) begin
                    w_pc_next          = branch_target;
                    w_if_id_valid_next = 1'b0;
                    w_state_next       = FETCH;
                end else if (!w_stall) begin
                    w_if_id_instr_next = r_hold_instr;
                    w_if_id_pc_next    = r_hold_pc;
                    w_if_id_valid_next = 1'b1;
                    w_pc_next          = r_pc + 32'd4;
                    w_state_next       = FETCH;
                end
            end
            DRAIN: begin
                if (is_control_hazard) begin
                    w_pc_next          = branch_target;
                    w_if_id_valid_next = 1'b0;
                end
                if (imem_ready) begin
                    w_state_next = FETCH;
                end
            end
            default: w_state_next = FETCH;
        endcase
    end

    assign imem_req    = (r_state != HOLD);
    assign imem_addr   = (r_state == DRAIN) ? r_req_addr : r_pc;
    assign pc          = r_pc;
    assign if_id_instr = r_if_id_instr;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_valid = r_if_id_valid;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (is_data_stall),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (is_control_hazard),
        .count (flush_count)
    );

endmodule : fetch_control_unit
